// File: rtl/fsm_flow_ctrl_multi.sv
// N-channel flow-control FSM: turns FIFO status flags into continuar/idle/pausa/error outputs.
// Optional pause watchdog enabled by defining FSM_PAUSE_WATCHDOG_EN.
module fsm_flow_ctrl_multi #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned UMBRAL_W      = 3,
  parameter int unsigned PAUSE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [UMBRAL_W-1:0] umbral_af,
  input  logic [UMBRAL_W-1:0] umbral_ae,
  input  logic [NUM_CH-1:0]   almost_full,
  input  logic [NUM_CH-1:0]   full,
  input  logic [NUM_CH-1:0]   almost_empty,
  input  logic [NUM_CH-1:0]   empty,
  output logic [UMBRAL_W-1:0] umbral_af_q,
  output logic [UMBRAL_W-1:0] umbral_ae_q,
  output logic                continuar,
  output logic [NUM_CH-1:0]   pausa,
  output logic [NUM_CH-1:0]   error_full,
  output logic                error_timeout,
  output logic                idle,
  output logic [2:0]          estado
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e state_q;

  logic any_full;
  logic all_empty;
  logic wd_hit;

  assign any_full  = |full;
  assign all_empty = &empty;
  assign estado    = state_q;

  // almost_empty is status only and never steers the FSM.
  logic unused_almost_empty;
  assign unused_almost_empty = ^almost_empty;

`ifdef FSM_PAUSE_WATCHDOG_EN
  localparam int unsigned PW = $clog2(PAUSE_TIMEOUT + 1);
  localparam logic [PW-1:0] PLIM = PW'(PAUSE_TIMEOUT);

  logic [PW-1:0] pcount_q;
  logic [PW-1:0] pcount_inc;
  logic          pause_edge;

  assign pause_edge = (state_q == StActive) && (|almost_full) && !any_full;
  assign pcount_inc = pcount_q + PW'(1);
  assign wd_hit     = pause_edge && (pcount_inc == PLIM);
`else
  assign wd_hit        = 1'b0;
  assign error_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StReset;
      umbral_af_q <= '0;
      umbral_ae_q <= '0;
      continuar   <= 1'b0;
      idle        <= 1'b0;
      pausa       <= '0;
      error_full  <= '0;
`ifdef FSM_PAUSE_WATCHDOG_EN
      error_timeout <= 1'b0;
      pcount_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StReset: begin
          state_q   <= StInit;
          continuar <= 1'b0;
          idle      <= 1'b0;
          pausa     <= '0;
        end
        StInit: begin
          umbral_af_q <= umbral_af;
          umbral_ae_q <= umbral_ae;
          if (iniciar) begin
            state_q   <= StIdle;
            continuar <= 1'b1;
            idle      <= 1'b1;
            pausa     <= '0;
          end else begin
            continuar <= 1'b0;
            idle      <= 1'b0;
            pausa     <= '0;
          end
        end
        StIdle: begin
          if (any_full) begin
            state_q    <= StError;
            continuar  <= 1'b0;
            idle       <= 1'b0;
            pausa      <= '1;
            error_full <= error_full | full;
          end else if (!all_empty) begin
            state_q   <= StActive;
            continuar <= 1'b1;
            idle      <= 1'b0;
            pausa     <= almost_full;
          end else begin
            continuar <= 1'b1;
            idle      <= 1'b1;
            pausa     <= '0;
          end
        end
        StActive: begin
          if (any_full) begin
            state_q    <= StError;
            continuar  <= 1'b0;
            idle       <= 1'b0;
            pausa      <= '1;
            error_full <= error_full | full;
          end else if (wd_hit) begin
            // Watchdog trip leaves error_full untouched.
            state_q   <= StError;
            continuar <= 1'b0;
            idle      <= 1'b0;
            pausa     <= '1;
          end else if (all_empty) begin
            state_q   <= StIdle;
            continuar <= 1'b1;
            idle      <= 1'b1;
            pausa     <= '0;
          end else begin
            continuar <= 1'b1;
            idle      <= 1'b0;
            pausa     <= almost_full;
          end
        end
        StError: begin
          continuar  <= 1'b0;
          idle       <= 1'b0;
          pausa      <= '1;
          error_full <= error_full | full;
        end
        default: begin
          state_q   <= StReset;
          continuar <= 1'b0;
          idle      <= 1'b0;
          pausa     <= '0;
        end
      endcase
`ifdef FSM_PAUSE_WATCHDOG_EN
      if (wd_hit) begin
        error_timeout <= 1'b1;
      end
      pcount_q <= (pause_edge && !wd_hit) ? pcount_inc : '0;
`endif
    end
  end

endmodule

// File: tb/tb_fsm_flow_ctrl_multi.sv
// Scoreboard bench for fsm_flow_ctrl_multi: driver pushes model predictions, monitor compares.
module tb_fsm_flow_ctrl_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned UW  = 3;
  localparam int unsigned PT  = 4;
`ifdef FSM_PAUSE_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           iniciar = 1'b0;
  logic [UW-1:0]  umbral_af = '0;
  logic [UW-1:0]  umbral_ae = '0;
  logic [NCH-1:0] almost_full = '0;
  logic [NCH-1:0] full = '0;
  logic [NCH-1:0] almost_empty = '0;
  logic [NCH-1:0] empty = '1;
  logic [UW-1:0]  umbral_af_q;
  logic [UW-1:0]  umbral_ae_q;
  logic           continuar;
  logic [NCH-1:0] pausa;
  logic [NCH-1:0] error_full;
  logic           error_timeout;
  logic           idle;
  logic [2:0]     estado;

  fsm_flow_ctrl_multi #(
    .NUM_CH(NCH),
    .UMBRAL_W(UW),
    .PAUSE_TIMEOUT(PT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iniciar(iniciar),
    .umbral_af(umbral_af),
    .umbral_ae(umbral_ae),
    .almost_full(almost_full),
    .full(full),
    .almost_empty(almost_empty),
    .empty(empty),
    .umbral_af_q(umbral_af_q),
    .umbral_ae_q(umbral_ae_q),
    .continuar(continuar),
    .pausa(pausa),
    .error_full(error_full),
    .error_timeout(error_timeout),
    .idle(idle),
    .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]     st;
    logic           cont;
    logic           idl;
    logic [NCH-1:0] pz;
    logic [NCH-1:0] ef;
    logic           to;
    logic [UW-1:0]  uaf;
    logic [UW-1:0]  uae;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;

  // Reference model state: state numbers follow the documented encoding.
  int             m_st = 0;
  int             m_pc = 0;
  logic [UW-1:0]  m_uaf = '0, m_uae = '0;
  logic [NCH-1:0] m_ef = '0, m_pz = '0;
  logic           m_to = 1'b0, m_cont = 1'b0, m_idl = 1'b0;

  function automatic obs_t dut_obs();
    return {estado, continuar, idle, pausa, error_full, error_timeout, umbral_af_q, umbral_ae_q};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got st=%0d cont=%b idle=%b pausa=%b ef=%b to=%b af_q=%0d ae_q=%0d | want st=%0d cont=%b idle=%b pausa=%b ef=%b to=%b af_q=%0d ae_q=%0d",
               name, got.st, got.cont, got.idl, got.pz, got.ef, got.to, got.uaf, got.uae,
               want.st, want.cont, want.idl, want.pz, want.ef, want.to, want.uaf, want.uae);
    end
  endtask

  task automatic model_step(input logic r, input logic ini, input logic [UW-1:0] taf,
                            input logic [UW-1:0] tae, input logic [NCH-1:0] afl,
                            input logic [NCH-1:0] fl, input logic [NCH-1:0] emp);
    int ns;
    bit hit;
    if (r) begin
      m_st = 0; m_pc = 0; m_uaf = '0; m_uae = '0; m_ef = '0; m_pz = '0;
      m_to = 0; m_cont = 0; m_idl = 0;
      return;
    end
    ns = m_st;
    hit = 0;
    case (m_st)
      0: ns = 1;
      1: begin
        m_uaf = taf;
        m_uae = tae;
        if (ini) ns = 2;
      end
      2: if (fl != 0) ns = 4; else if (emp != '1) ns = 3;
      3: begin
        hit = WdEn && fl == 0 && afl != 0 && (m_pc + 1 == PT);
        if (fl != 0 || hit) ns = 4;
        else if (emp == '1) ns = 2;
      end
      default: ns = 4;
    endcase
    m_pc = (WdEn && m_st == 3 && afl != 0 && fl == 0 && !hit) ? m_pc + 1 : 0;
    if (hit) m_to = 1;
    if (ns == 4) m_ef = m_ef | fl;
    m_cont = (ns == 2 || ns == 3);
    m_idl  = (ns == 2);
    m_pz   = (ns == 4) ? '1 : (ns == 3) ? afl : '0;
    m_st   = ns;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic cyc(input logic r, input logic ini, input logic [UW-1:0] taf,
                     input logic [UW-1:0] tae, input logic [NCH-1:0] afl,
                     input logic [NCH-1:0] fl, input logic [NCH-1:0] emp);
    obs_t e;
    @(negedge clk);
    reset = r; iniciar = ini; umbral_af = taf; umbral_ae = tae;
    almost_full = afl; full = fl; empty = emp;
    almost_empty = $urandom_range(0, 15);
    if (r) begin
      #1;
      check("async_reset", dut_obs(), '0);
    end
    model_step(r, ini, taf, tae, afl, fl, emp);
    e = {m_st[2:0], m_cont, m_idl, m_pz, m_ef, m_to, m_uaf, m_uae};
    exp_q.push_back(e);
  endtask

  // Monitor: one registered observation per rising edge.
  initial begin
    obs_t w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        ncyc++;
        check($sformatf("cycle%0d", ncyc), dut_obs(), w);
      end
    end
  end

  initial begin
    logic [NCH-1:0] afl, fl, emp;
    logic [UW-1:0]  taf, tae;
    int n;

    // Reset and init
    cyc(1, 0, 0, 0, 0, 0, '1);
    cyc(1, 0, 0, 0, 0, 0, '1);
    cyc(0, 0, 3'd6, 3'd1, 0, 0, '1);
    cyc(0, 1, 3'd6, 3'd1, 0, 0, '1);
    cyc(0, 0, 3'd2, 3'd5, 0, 0, '1);
    // Traffic
    cyc(0, 0, 3'd2, 3'd5, 0, 0, 4'b1011);
    cyc(0, 0, 0, 0, 0, 0, 4'b1111);
    cyc(0, 0, 0, 0, 0, 0, 4'b1011);
    // Pause
    cyc(0, 0, 0, 0, 4'b0100, 0, 4'b1011);
    cyc(0, 0, 0, 0, 4'b0000, 0, 4'b1011);
    // Overflow, then iniciar ignored
    cyc(0, 0, 0, 0, 0, 4'b0010, 4'b1011);
    cyc(0, 1, 0, 0, 0, 4'b1000, 4'b1011);
    cyc(0, 1, 0, 0, 0, 0, 4'b1011);
    // Reset while in ERROR
    cyc(1, 0, 0, 0, 0, 0, '1);
    // Watchdog
    cyc(0, 0, 3'd6, 3'd1, 0, 0, '1);
    cyc(0, 1, 3'd6, 3'd1, 0, 0, '1);
    cyc(0, 0, 0, 0, 0, 0, 4'b1110);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'b0001, 0, 4'b1110);

    // Random episodes
    for (int ep = 0; ep < 40; ep++) begin
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) cyc(1, $urandom_range(0, 1), 0, 0, 0, 0, '1);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        taf = $urandom_range(0, 7);
        tae = $urandom_range(0, 7);
        cyc(0, (i == n - 1) ? 1'b1 : 1'b0, taf, tae, 0, 0, '1);
      end
      afl = '0;
      n = $urandom_range(20, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) afl = $urandom_range(0, 15);
        emp = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
        fl  = ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        if (fl != 0 && $urandom_range(0, 1) == 1) emp = emp | fl;
        taf = $urandom_range(0, 7);
        tae = $urandom_range(0, 7);
        cyc(0, $urandom_range(0, 1), taf, tae, afl, fl, emp);
      end
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
